// File: rtl/csr_timer_unit.sv
// csr_timer_unit: timer CSRs (TID, TCFG, TVAL, TICLR, CNTC) and the 64-bit
// stable counter. It consumes the CSR-write stream, answers reads for the
// addresses it owns and drives the timer interrupt line.

package csr_defines;
    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [31:0] data;
    } csr_write_signal;

    localparam logic [13:0] CSR_TID   = 14'h40;
    localparam logic [13:0] CSR_TCFG  = 14'h41;
    localparam logic [13:0] CSR_TVAL  = 14'h42;
    localparam logic [13:0] CSR_CNTC  = 14'h43;
    localparam logic [13:0] CSR_TICLR = 14'h44;
endpackage

module csr_timer_unit
    import csr_defines::*;
#(
    parameter logic [31:0] COREID = 32'd0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  csr_defines::csr_write_signal csr_w_i,
    input  logic [13:0]                  rd_addr_i,
    output logic [31:0]                  rd_data_o,
    output logic                         rd_hit_o,
    output logic                         timer_int_o,
    output logic [63:0]                  stable_counter_o
);

    logic [31:0] tid;
    logic [31:0] tcfg;
    logic [31:0] tval;
    logic        armed;
    logic        pending;
    logic [31:0] cntc;
    logic [63:0] cnt;

    logic wr_tid;
    logic wr_tcfg;
    logic wr_cntc;
    logic wr_ticlr;
    logic timer_run;
    logic expire;

    // Decode the write stream; TVAL is read-only so it has no strobe.
    assign wr_tid   = csr_w_i.we && (csr_w_i.addr == CSR_TID);
    assign wr_tcfg  = csr_w_i.we && (csr_w_i.addr == CSR_TCFG);
    assign wr_cntc  = csr_w_i.we && (csr_w_i.addr == CSR_CNTC);
    assign wr_ticlr = csr_w_i.we && (csr_w_i.addr == CSR_TICLR);

    // A TCFG write suppresses the timer step for that cycle, so the write wins
    // over a coincident expiry.
    assign timer_run = !wr_tcfg && armed && tcfg[0];
    assign expire    = timer_run && (tval == 32'd0);

    // TID holds the core id until software overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tid <= COREID;
        end else if (wr_tid) begin
            tid <= csr_w_i.data;
        end
    end

    // Timer configuration and countdown: load on TCFG write, otherwise count
    // down, reloading in periodic mode or disarming in one-shot mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcfg  <= 32'd0;
            tval  <= 32'd0;
            armed <= 1'b0;
        end else if (wr_tcfg) begin
            tcfg  <= csr_w_i.data;
            tval  <= {csr_w_i.data[31:2], 2'b00};
            armed <= csr_w_i.data[0];
        end else if (timer_run) begin
            if (tval != 32'd0) begin
                tval <= tval - 32'd1;
            end else if (tcfg[1]) begin
                tval <= {tcfg[31:2], 2'b00};
            end else begin
                armed <= 1'b0;
            end
        end
    end

    // Interrupt pending flag; an expiry beats a simultaneous TICLR clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (expire) begin
            pending <= 1'b1;
        end else if (wr_ticlr && csr_w_i.data[0]) begin
            pending <= 1'b0;
        end
    end

    // Counter correction value added to the free-running count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntc <= 32'd0;
        end else if (wr_cntc) begin
            cntc <= csr_w_i.data;
        end
    end

    // Free-running 64-bit counter, wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 64'd0;
        end else begin
            cnt <= cnt + 64'd1;
        end
    end

    assign timer_int_o      = pending;
    assign stable_counter_o = cnt + {{32{cntc[31]}}, cntc};

    // Combinational read port from current state; same-cycle writes are not
    // forwarded.
    always_comb begin
        rd_data_o = 32'd0;
        rd_hit_o  = 1'b0;
        case (rd_addr_i)
            CSR_TID: begin
                rd_data_o = tid;
                rd_hit_o  = 1'b1;
            end
            CSR_TCFG: begin
                rd_data_o = tcfg;
                rd_hit_o  = 1'b1;
            end
            CSR_TVAL: begin
                rd_data_o = tval;
                rd_hit_o  = 1'b1;
            end
            CSR_CNTC: begin
                rd_data_o = cntc;
                rd_hit_o  = 1'b1;
            end
            CSR_TICLR: begin
                rd_data_o = 32'd0;
                rd_hit_o  = 1'b1;
            end
            default: begin
                rd_data_o = 32'd0;
                rd_hit_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_timer_unit.sv
// tb_csr_timer_unit: directed test of the timer CSR block with hand-computed
// expected values.

module tb_csr_timer_unit;

    localparam logic [13:0] A_TID   = 14'h40;
    localparam logic [13:0] A_TCFG  = 14'h41;
    localparam logic [13:0] A_TVAL  = 14'h42;
    localparam logic [13:0] A_CNTC  = 14'h43;
    localparam logic [13:0] A_TICLR = 14'h44;

    logic                         clk;
    logic                         rst;
    csr_defines::csr_write_signal csr_w;
    logic [13:0]                  rd_addr;
    logic [31:0]                  rd_data;
    logic                         rd_hit;
    logic                         timer_int;
    logic [63:0]                  stable_counter;

    int checksTotal;
    int checksPassed;
    int edges;

    csr_timer_unit #(.COREID(32'd5)) dut (
        .clk              (clk),
        .rst              (rst),
        .csr_w_i          (csr_w),
        .rd_addr_i        (rd_addr),
        .rd_data_o        (rd_data),
        .rd_hit_o         (rd_hit),
        .timer_int_o      (timer_int),
        .stable_counter_o (stable_counter)
    );

    // 10 ns core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checksTotal++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end else begin
            checksPassed++;
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Present one CSR write for exactly one clock edge.
    task automatic applyStimulus(input logic [13:0] addr, input logic [31:0] data);
        csr_w.we   = 1'b1;
        csr_w.addr = addr;
        csr_w.data = data;
        tick();
        csr_w.we   = 1'b0;
        csr_w.addr = 14'h0;
        csr_w.data = 32'h0;
    endtask

    // Point the read port at an address and check data and hit.
    task automatic readCheck(input string tag, input logic [13:0] addr,
                             input logic [31:0] expData, input logic expHit);
        rd_addr = addr;
        #1;
        checkOutput({tag, "_data"}, {32'd0, rd_data}, {32'd0, expData});
        checkOutput({tag, "_hit"}, {63'd0, rd_hit}, {63'd0, expHit});
    endtask

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        edges        = 0;
        rst          = 1'b1;
        csr_w        = '0;
        rd_addr      = A_TVAL;

        // Reset state and read map.
        tick();
        tick();
        readCheck("rst_tid", A_TID, 32'd5, 1'b1);
        readCheck("rst_tcfg", A_TCFG, 32'd0, 1'b1);
        readCheck("rst_tval", A_TVAL, 32'd0, 1'b1);
        readCheck("rst_ticlr", A_TICLR, 32'd0, 1'b1);
        readCheck("rst_cntc", A_CNTC, 32'd0, 1'b1);
        readCheck("rst_unowned", 14'h7, 32'd0, 1'b0);
        checkOutput("rst_int", {63'd0, timer_int}, 64'd0);
        checkOutput("rst_stable", stable_counter, 64'd0);

        rst   = 1'b0;
        edges = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("stable_count_%0d", i), stable_counter, 64'(i));
        end

        // TID write and readback.
        applyStimulus(A_TID, 32'hDEAD_BEEF);
        readCheck("tid_write", A_TID, 32'hDEAD_BEEF, 1'b1);

        // CNTC: write -10 while cnt is 100.
        while (edges < 100) tick();
        applyStimulus(A_CNTC, 32'hFFFF_FFF6);
        checkOutput("cntc_neg", stable_counter, 64'd91);
        tick();
        checkOutput("cntc_neg_inc", stable_counter, 64'd92);
        applyStimulus(A_CNTC, 32'h7FFF_FFFF);
        checkOutput("cntc_pos", stable_counter, 64'(edges) + 64'h0000_0000_7FFF_FFFF);
        checkOutput("cntc_pos_upper", {32'd0, stable_counter[63:32]}, 64'd0);
        readCheck("cntc_read", A_CNTC, 32'h7FFF_FFFF, 1'b1);
        rd_addr = A_TVAL;

        // One-shot INITVAL=1: TVAL 4..0, interrupt 5 cycles after the write.
        applyStimulus(A_TCFG, 32'h0000_0005);
        checkOutput("os_tval_0", {32'd0, rd_data}, 64'd4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("os_tval_%0d", i), {32'd0, rd_data}, 64'(4 - i));
            checkOutput($sformatf("os_int_low_%0d", i), {63'd0, timer_int}, 64'd0);
        end
        tick();
        checkOutput("os_int_rise", {63'd0, timer_int}, 64'd1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("os_int_hold", {63'd0, timer_int}, 64'd1);
        checkOutput("os_tval_hold", {32'd0, rd_data}, 64'd0);
        applyStimulus(A_TICLR, 32'h1);
        checkOutput("os_int_clear", {63'd0, timer_int}, 64'd0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("os_no_reassert", {63'd0, timer_int}, 64'd0);

        // Periodic INITVAL=2: expiry every 9 cycles, set beats clear.
        applyStimulus(A_TCFG, 32'h0000_000B);
        checkOutput("per_tval_load", {32'd0, rd_data}, 64'd8);
        for (int i = 1; i <= 8; i++) tick();
        checkOutput("per_tval_zero", {32'd0, rd_data}, 64'd0);
        checkOutput("per_int_low", {63'd0, timer_int}, 64'd0);
        tick();
        checkOutput("per_int_rise", {63'd0, timer_int}, 64'd1);
        checkOutput("per_reload", {32'd0, rd_data}, 64'd8);
        applyStimulus(A_TICLR, 32'h1);
        checkOutput("per_clear", {63'd0, timer_int}, 64'd0);
        checkOutput("per_tval_7", {32'd0, rd_data}, 64'd7);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("per_tval_zero2", {32'd0, rd_data}, 64'd0);
        applyStimulus(A_TICLR, 32'h1);
        checkOutput("per_set_wins", {63'd0, timer_int}, 64'd1);
        checkOutput("per_reload2", {32'd0, rd_data}, 64'd8);

        // Re-write mid-count; TCFG write leaves pending alone.
        applyStimulus(A_TCFG, 32'h0000_0041);
        checkOutput("rw_pending_kept", {63'd0, timer_int}, 64'd1);
        checkOutput("rw_tval_64", {32'd0, rd_data}, 64'd64);
        applyStimulus(A_TICLR, 32'h1);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("rw_tval_54", {32'd0, rd_data}, 64'd54);
        applyStimulus(A_TCFG, 32'h0000_0009);
        checkOutput("rw_tval_8", {32'd0, rd_data}, 64'd8);
        applyStimulus(A_TVAL, 32'h0000_1234);
        checkOutput("rw_tval_ro", {32'd0, rd_data}, 64'd7);
        for (int i = 2; i <= 8; i++) begin
            tick();
            checkOutput($sformatf("rw_int_low_%0d", i), {63'd0, timer_int}, 64'd0);
        end
        checkOutput("rw_tval_zero", {32'd0, rd_data}, 64'd0);
        tick();
        checkOutput("rw_int_rise", {63'd0, timer_int}, 64'd1);

        // EN=0 loads TVAL and freezes it.
        applyStimulus(A_TCFG, 32'h0000_0010);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("en0_frozen", {32'd0, rd_data}, 64'd16);
        readCheck("en0_tcfg", A_TCFG, 32'h0000_0010, 1'b1);
        rd_addr = A_TVAL;

        // Async reset while a periodic timer runs with pending set.
        applyStimulus(A_TCFG, 32'h0000_000B);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("ar_pre_int", {63'd0, timer_int}, 64'd1);
        checkOutput("ar_pre_tval", {32'd0, rd_data}, 64'd5);
        rst = 1'b1;
        #1;
        checkOutput("ar_int_drop", {63'd0, timer_int}, 64'd0);
        checkOutput("ar_tval_zero", {32'd0, rd_data}, 64'd0);
        checkOutput("ar_stable_zero", stable_counter, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("ar_no_int", {63'd0, timer_int}, 64'd0);
        checkOutput("ar_tval_idle", {32'd0, rd_data}, 64'd0);
        readCheck("ar_tid", A_TID, 32'd5, 1'b1);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/csr_timer_unit.md
# csr_timer_unit

Owns the timer-related CSRs: TID, TCFG, TVAL, TICLR and CNTC. Also owns the 64-bit stable counter. It is the consumer of the `csr_write_signal` stream that the CSR-write stage produces. It returns read data for the addresses it owns and drives the timer interrupt line that feeds ESTAT.IS[11].

## Interface
- `COREID`, default 0: reset value of TID.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `csr_w_i`  in  `csr_defines::csr_write_signal` (47 bits)  write request: `we`, `addr[13:0]`, `data[31:0]`.
- `rd_addr_i`  in  14  CSR read address.
- `rd_data_o`  out  32  read data for `rd_addr_i`.
- `rd_hit_o`  out  1  `rd_addr_i` is one of TID/TCFG/TVAL/TICLR/CNTC.
- `timer_int_o`  out  1  timer interrupt pending (ESTAT.IS[11]).
- `stable_counter_o`  out  64  free counter plus the sign-extended CNTC.

## Operation
- State:
  - tid[31:0]
  - tcfg[31:0], with fields EN bit 0, PERIODIC bit 1, INITVAL bits 31:2
  - tval[31:0]
  - armed
  - pending
  - cntc[31:0]
  - cnt[63:0]
- Reset values:
  - tid=COREID; every other register 0.
  - `timer_int_o`=0, `stable_counter_o`=0.
  - `rd_data_o`/`rd_hit_o` follow `rd_addr_i` from the reset register values.
- Writes are applied only when `csr_w_i.we`=1. Addresses not listed below are ignored.
  - TID (0x40): tid <= data.
  - TCFG (0x41): tcfg <= data; tval <= {data[31:2],2'b00}; armed <= data[0].
  - TVAL (0x42): read-only; writes ignored.
  - TICLR (0x44): if data[0]=1, pending <= 0.
  - CNTC (0x43): cntc <= data.
- Timer step, evaluated every cycle in which there is no TCFG write, when armed=1 and EN=1:
  - If tval≠0: tval <= tval−1.
  - If tval=0 (expiry):
    - pending <= 1.
    - If PERIODIC=1: tval <= {INITVAL,2'b00}.
    - Otherwise: armed <= 0 and tval holds 0.
- Reads are combinational from current register state. A write in the same cycle is not bypassed.
  - TID → tid; TCFG → tcfg; TVAL → tval; CNTC → cntc.
  - TICLR → 0.
  - Unowned address → `rd_data_o`=0, `rd_hit_o`=0.
- `timer_int_o` = pending.
- cnt increments by 1 every cycle and wraps at 2^64 to 0.
- `stable_counter_o` = cnt + {{32{cntc[31]}},cntc}, mod 2^64, combinational.

## Timing
- Write latency: a write sampled at edge E is visible on reads and outputs after E.
- One-shot latency:
  - TCFG written at edge E0 with INITVAL=k loads N=4k.
  - tval reaches 0 at edge E0+N.
  - pending rises at edge E0+N+1.
  - `timer_int_o` is therefore high N+1 cycles after the write edge.
- Periodic mode: pending is set every N+1 cycles; tval sequence is N…0, N….
- INITVAL=0 with EN=1: tval=0 after E0; pending set at E0+1. In periodic mode pending is set every cycle.
- Simultaneous events:
  - TCFG write in the same cycle as an expiry: the write wins. No pending set, no reload, tval is loaded from the write data.
  - TICLR clear in the same cycle as an expiry: the set wins, and pending stays 1.
  - TCFG write never changes pending.
- TCFG write with EN=0: tval is loaded, then frozen; armed=0.
- Re-enable: a later TCFG write with EN=1 restarts from the new INITVAL.
- cntc change takes effect on `stable_counter_o` in the cycle after the write edge. cnt is not modified by the write.
- Async reset mid-count: all state returns to reset values immediately. `timer_int_o` drops in the same cycle as `rst` asserts.

## Test plan
- Reset with COREID=5, then read 0x40, 0x41, 0x42, 0x44, 0x43, 0x7 → 5, 0, 0, 0, 0 with `rd_hit_o`=1 for all five; 0x7 gives 0 with `rd_hit_o`=0. `stable_counter_o` counts 1, 2, 3 on successive cycles.
- One-shot: write TCFG=0x0000_0005 (INITVAL=1, EN=1) → TVAL reads 4, 3, 2, 1, 0. `timer_int_o` rises 5 cycles after the write edge and stays high; TVAL stays 0. Writing TICLR=1 clears `timer_int_o` on the next edge, and it does not reassert.
- Periodic: write TCFG=0x0000_000B (INITVAL=2, EN=1, PERIODIC=1) → pending set every 9 cycles. Issue TICLR=1 exactly on an expiry cycle → `timer_int_o` stays 1.
- Re-write mid-count: TCFG=0x41 (INITVAL=16, EN=1, N=64). After 10 cycles write TCFG=0x0000_0009 → TVAL=8 next cycle, no interrupt from the old count, interrupt 9 cycles after the second write. Writing TVAL=0x1234 leaves TVAL unchanged.
- CNTC: at cnt=100 write CNTC=0xFFFF_FFF6 (−10) → `stable_counter_o` continues from 100+1−10=91 and increments by 1 per cycle. Write CNTC=0x7FFF_FFFF → offset +2^31−1 applied with no sign extension into the upper word.
- Async reset asserted while periodic timer and pending active → `timer_int_o`=0 and TVAL=0 immediately. No interrupt occurs after release until TCFG is written again.
